// File: rtl/cd40147_priority_encoder.sv
// 10-to-4 BCD priority encoder (CD40147 style): highest active line wins, 1-cycle registered or 0-cycle combinational (OUT_REG).
// No backpressure; i is sampled every cycle. Define CD40147_ACTIVE_LOW_EN for device pin polarity (active-low i, inverted o).
module cd40147_priority_encoder #(
   parameter int OUT_REG = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] i,
   output logic [3:0] o,
   output logic       valid
);

`ifdef CD40147_ACTIVE_LOW_EN
   localparam logic [3:0] O_RST = 4'b1111;
   logic [9:0] act;
   assign act = ~i;
`else
   localparam logic [3:0] O_RST = 4'b0000;
   logic [9:0] act;
   assign act = i;
`endif

   logic [3:0] enc;
   logic [3:0] o_c;
   logic       valid_c;

   // Line 0 and no active line both encode to 0; only valid tells them apart.
   always_comb begin
      enc = 4'd0;
      if (act[9])      enc = 4'd9;
      else if (act[8]) enc = 4'd8;
      else if (act[7]) enc = 4'd7;
      else if (act[6]) enc = 4'd6;
      else if (act[5]) enc = 4'd5;
      else if (act[4]) enc = 4'd4;
      else if (act[3]) enc = 4'd3;
      else if (act[2]) enc = 4'd2;
      else if (act[1]) enc = 4'd1;
   end

`ifdef CD40147_ACTIVE_LOW_EN
   assign o_c = ~enc;
`else
   assign o_c = enc;
`endif
   assign valid_c = |act;

   generate
      if (OUT_REG != 0) begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               o     <= O_RST;
               valid <= 1'b0;
            end else begin
               o     <= o_c;
               valid <= valid_c;
            end
         end
      end else begin : g_comb
         assign o     = o_c;
         assign valid = valid_c;
      end
   endgenerate

endmodule

// File: tb/tb_cd40147_priority_encoder.sv
// Bench for cd40147_priority_encoder: registered and combinational instances checked against a reference model and literals.
module tb_cd40147_priority_encoder;

`ifdef CD40147_ACTIVE_LOW_EN
   localparam bit AL = 1'b1;
`else
   localparam bit AL = 1'b0;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [9:0] i     = '0;
   logic [3:0] o_r, o_c;
   logic       v_r, v_c;
   logic       mon   = 1'b0;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   cd40147_priority_encoder #(.OUT_REG(1)) dut_r (
      .clk(clk), .rst_n(rst_n), .i(i), .o(o_r), .valid(v_r)
   );

   cd40147_priority_encoder #(.OUT_REG(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .i(i), .o(o_c), .valid(v_c)
   );

   // Highest set index by scanning upward; empty vector gives 0.
   function automatic logic [3:0] bcd_of(input logic [9:0] act);
      int best = 0;
      for (int k = 0; k < 10; k++)
         if (act[k]) best = k;
      return 4'(best);
   endfunction

   function automatic logic [9:0] pin(input logic [9:0] v);
      return AL ? ~v : v;
   endfunction

   function automatic logic [3:0] pout(input logic [3:0] c);
      return AL ? ~c : c;
   endfunction

   function automatic logic [3:0] model_o(input logic [9:0] raw);
      return pout(bcd_of(pin(raw)));
   endfunction

   function automatic logic model_v(input logic [9:0] raw);
      return |pin(raw);
   endfunction

   logic [3:0] rst_o;
   assign rst_o = pout(4'd0);

   task automatic check(input string name, input logic [3:0] got_o, input logic got_v,
                        input logic [3:0] exp_o, input logic exp_v);
      checks++;
      if (got_o !== exp_o || got_v !== exp_v) begin
         errors++;
         $display("FAIL %s: got o=%b valid=%b, expected o=%b valid=%b at %0t",
                  name, got_o, got_v, exp_o, exp_v, $time);
      end
   endtask

   // Reference for the registered instance: value of the model at the last edge, cleared by reset.
   logic [3:0] ref_o = '0;
   logic       ref_v = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_o <= rst_o;
         ref_v <= 1'b0;
      end else begin
         ref_o <= model_o(i);
         ref_v <= model_v(i);
      end
   end

   always @(negedge clk) begin
      if (mon) begin
         check("model_reg", o_r, v_r, ref_o, ref_v);
         check("model_comb", o_c, v_c, model_o(i), model_v(i));
      end
   end

   task automatic apply(input logic [9:0] v, input logic [3:0] exp_code, input logic exp_v,
                        input string name);
      @(posedge clk);
      #2 i = pin(v);
      #1 check({name, "_comb"}, o_c, v_c, pout(exp_code), exp_v);
      @(posedge clk);
      #1 check({name, "_reg"}, o_r, v_r, pout(exp_code), exp_v);
   endtask

   initial begin
      i = pin(10'd0);
      #1 rst_n = 1'b0;
      #1 mon = 1'b1;

      // Reset holds outputs while line 9 is active and the clock runs.
      i = pin(10'b1000000000);
      repeat (3) @(posedge clk);
      #1 check("rst_hold", o_r, v_r, rst_o, 1'b0);
      check("rst_comb", o_c, v_c, pout(4'd9), 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1 check("rst_before_edge", o_r, v_r, rst_o, 1'b0);
      @(posedge clk);
      #1 check("rst_release", o_r, v_r, pout(4'd9), 1'b1);

      apply(10'd0, 4'd0, 1'b0, "onehot_none");
      for (int k = 0; k < 10; k++)
         apply(10'(1 << k), 4'(k), 1'b1, $sformatf("onehot_%0d", k));

      apply(10'b1100000000, 4'd9, 1'b1, "pri_9");
      apply(10'b0111111111, 4'd8, 1'b1, "pri_8");
      apply(10'b0000000110, 4'd2, 1'b1, "pri_2");
      apply(10'b0000000000, 4'd0, 1'b0, "zero");
      apply(10'b0000000001, 4'd0, 1'b1, "line0");

      // Asynchronous reset between edges clears the registered outputs at once.
      apply(10'b1000000000, 4'd9, 1'b1, "pre_async");
      #2 rst_n = 1'b0;
      #1 check("async_rst", o_r, v_r, rst_o, 1'b0);
      check("async_comb", o_c, v_c, pout(4'd9), 1'b1);
      @(posedge clk);
      #1 check("async_held", o_r, v_r, rst_o, 1'b0);
      #1 rst_n = 1'b1;
      i = pin(10'b0000100000);
      @(posedge clk);
      #1 check("post_async", o_r, v_r, pout(4'd5), 1'b1);

      @(negedge clk);
      #1 mon = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
